// File: rtl/clk_en_gen_if.sv
// -----------------------------------------------------------------------------
// clk_en_gen_if
// Bundles the configuration bus, the per-channel run enables and the
// generator outputs of clk_en_gen. Clock and reset stay as plain ports.
//
// Signals:
//   CFG_WE      config write strobe (single cycle)
//   CFG_CH      channel index of the write
//   CFG_DIV     divide ratio of the write
//   CFG_PHASE   phase offset of the write
//   CH_EN       per-channel run enable
//   CE_OUT      one-cycle enable pulse per divided period, per channel
//   CLKOUT      registered divided square wave, per channel
//   LOCKED_OUT  all channels stable
//   CFG_ERR     one-cycle pulse on a rejected write
//
// Modports:
//   master  drives config and enables, observes outputs
//   slave   the generator itself
// -----------------------------------------------------------------------------
interface clk_en_gen_if #(
  parameter int NUM_CH = 6,
  parameter int DIV_W  = 8,
  parameter int CH_W   = 3
);
  logic              CFG_WE;
  logic [CH_W-1:0]   CFG_CH;
  logic [DIV_W-1:0]  CFG_DIV;
  logic [DIV_W-1:0]  CFG_PHASE;
  logic [NUM_CH-1:0] CH_EN;
  logic [NUM_CH-1:0] CE_OUT;
  logic [NUM_CH-1:0] CLKOUT;
  logic              LOCKED_OUT;
  logic              CFG_ERR;

  modport master (
    output CFG_WE, CFG_CH, CFG_DIV, CFG_PHASE, CH_EN,
    input  CE_OUT, CLKOUT, LOCKED_OUT, CFG_ERR
  );

  modport slave (
    input  CFG_WE, CFG_CH, CFG_DIV, CFG_PHASE, CH_EN,
    output CE_OUT, CLKOUT, LOCKED_OUT, CFG_ERR
  );
endinterface

// File: rtl/clk_en_gen.sv
// -----------------------------------------------------------------------------
// clk_en_gen
// Multi-channel clock-enable generator. Each channel divides CLKIN_IN by a
// run-time programmable ratio with a programmable phase and produces a
// one-cycle enable pulse (CE_OUT) and a registered square wave (CLKOUT).
// A lock counter reports LOCKED_OUT once LOCK_CYCLES edges have passed
// without a reset or an accepted configuration write.
//
// Ports:
//   CLKIN_IN  in   sole clock, rising edge
//   RST_IN    in   synchronous active-high reset
//   bus       clk_en_gen_if.slave : CFG_WE/CFG_CH/CFG_DIV/CFG_PHASE/CH_EN in,
//             CE_OUT/CLKOUT/LOCKED_OUT/CFG_ERR out
//
// Per-channel invariant: cnt < div and phase < div at all times, which
// lets the square-wave phase distance be formed with one conditional add
// instead of a true modulo.
// -----------------------------------------------------------------------------
module clk_en_gen #(
  parameter int NUM_CH      = 6,
  parameter int DIV_W       = 8,
  parameter int CH_W        = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic          CLKIN_IN,
  input  logic          RST_IN,
  clk_en_gen_if.slave   bus
);

  localparam int                LK_W     = $clog2(LOCK_CYCLES + 1);
  localparam logic [CH_W:0]     NUM_CH_C = (CH_W+1)'(NUM_CH);
  localparam logic [LK_W-1:0]   LOCK_MAX = LK_W'(LOCK_CYCLES);
  localparam logic [DIV_W-1:0]  DIV_RST  = DIV_W'(2);

  // Per-channel configuration and counter state
  logic [DIV_W-1:0]  r_div   [NUM_CH];
  logic [DIV_W-1:0]  r_phase [NUM_CH];
  logic [DIV_W-1:0]  r_cnt   [NUM_CH];

  logic [NUM_CH-1:0] r_ce_p1;
  logic [NUM_CH-1:0] r_clk_p1;
  logic [LK_W-1:0]   r_lock_cnt;
  logic              r_locked_p1;
  logic              r_err_p1;

  logic              w_cfg_valid;
  logic              w_wr_acc;
  logic              w_wr_rej;
  logic [NUM_CH-1:0] w_wr_sel;
  logic [LK_W-1:0]   w_lock_nxt;

  // Saturating increment of the lock counter.
  function automatic logic [LK_W-1:0] sat_inc_lock(input logic [LK_W-1:0] v);
    if (v >= LOCK_MAX) return LOCK_MAX;
    return v + LK_W'(1);
  endfunction

  // Channel counter advance, wrapping at div-1.
  function automatic logic [DIV_W-1:0] wrap_inc(input logic [DIV_W-1:0] cnt,
                                                input logic [DIV_W-1:0] div);
    return (cnt == div - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
  endfunction

  // Square-wave level: high while (cnt - phase) mod div is in the first
  // ceil(div/2) positions, so odd ratios get the extra high cycle.
  function automatic logic sq_high(input logic [DIV_W-1:0] cnt,
                                   input logic [DIV_W-1:0] phase,
                                   input logic [DIV_W-1:0] div);
    logic [DIV_W:0] p;
    logic [DIV_W:0] half;
    if (cnt >= phase) p = {1'b0, cnt} - {1'b0, phase};
    else              p = {1'b0, cnt} + {1'b0, div} - {1'b0, phase};
    half = ({1'b0, div} + (DIV_W+1)'(1)) >> 1;
    return (p < half);
  endfunction

  // Stage p0: write qualification and lock-counter next value
  always_comb begin
    w_cfg_valid = ({1'b0, bus.CFG_CH} < NUM_CH_C) &&
                  (bus.CFG_DIV != '0) &&
                  (bus.CFG_PHASE < bus.CFG_DIV);
    w_wr_acc    = bus.CFG_WE && w_cfg_valid;
    w_wr_rej    = bus.CFG_WE && !w_cfg_valid;
    w_wr_sel    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_wr_sel[i] = w_wr_acc && ({1'b0, bus.CFG_CH} == (CH_W+1)'(i));
    end
    w_lock_nxt  = w_wr_acc ? '0 : sat_inc_lock(r_lock_cnt);
  end

  // Stage p1: counters, configuration and registered outputs
  always_ff @(posedge CLKIN_IN) begin
    if (RST_IN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_div[i]   <= DIV_RST;
        r_phase[i] <= '0;
        r_cnt[i]   <= '0;
      end
      r_ce_p1     <= '0;
      r_clk_p1    <= '0;
      r_lock_cnt  <= '0;
      r_locked_p1 <= 1'b0;
      r_err_p1    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_sel[i]) begin
          // New ratio takes effect from cnt=0 on the following edge;
          // outputs are held low on the write edge itself.
          r_div[i]    <= bus.CFG_DIV;
          r_phase[i]  <= bus.CFG_PHASE;
          r_cnt[i]    <= '0;
          r_ce_p1[i]  <= 1'b0;
          r_clk_p1[i] <= 1'b0;
        end else if (!bus.CH_EN[i]) begin
          r_cnt[i]    <= '0;
          r_ce_p1[i]  <= 1'b0;
          r_clk_p1[i] <= 1'b0;
        end else begin
          r_ce_p1[i]  <= (r_cnt[i] == r_phase[i]);
          r_clk_p1[i] <= sq_high(r_cnt[i], r_phase[i], r_div[i]);
          r_cnt[i]    <= wrap_inc(r_cnt[i], r_div[i]);
        end
      end
      r_lock_cnt  <= w_lock_nxt;
      r_locked_p1 <= (w_lock_nxt == LOCK_MAX);
      r_err_p1    <= w_wr_rej;
    end
  end

  assign bus.CE_OUT     = r_ce_p1;
  assign bus.CLKOUT     = r_clk_p1;
  assign bus.LOCKED_OUT = r_locked_p1;
  assign bus.CFG_ERR    = r_err_p1;

endmodule

// File: tb/tb_clk_en_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_en_gen
// Directed bench for clk_en_gen. The stimulus process drives one cycle at a
// time and pushes the hand-derived output expectation for the following edge
// into a queue; an independent monitor pops and compares after each edge.
// Each channel's expected waveform is a closed-form pattern of the number of
// enabled edges since that channel was (re)started.
// -----------------------------------------------------------------------------
module tb_clk_en_gen;
  localparam int NCH = 6;
  localparam int DW  = 8;
  localparam int CW  = 3;
  localparam int LC  = 16;

  localparam int M_D2   = 0;  // div=2 phase=0 : alternate 1,0,...
  localparam int M_D5P2 = 1;  // div=5 phase=2
  localparam int M_D1   = 2;  // div=1 : constant 1
  localparam int M_D255 = 3;  // div=255 phase=254

  logic CLKIN_IN = 1'b0;
  logic RST_IN;

  clk_en_gen_if #(.NUM_CH(NCH), .DIV_W(DW), .CH_W(CW)) bus ();

  clk_en_gen #(.NUM_CH(NCH), .DIV_W(DW), .CH_W(CW), .LOCK_CYCLES(LC)) dut (
    .CLKIN_IN (CLKIN_IN),
    .RST_IN   (RST_IN),
    .bus      (bus)
  );

  always #5 CLKIN_IN = ~CLKIN_IN;

  typedef struct {
    logic [NCH-1:0] ce;
    logic [NCH-1:0] clk;
    logic           lk;
    logic           err;
    string          tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   s[NCH];
  int   mode[NCH];
  int   lk_n;

  // {ce, clkout} for a channel in mode md on its sv-th enabled edge (sv>=1).
  function automatic logic [1:0] ch_exp(input int md, input int sv);
    int c;
    case (md)
      M_D2:    return {sv % 2 == 1, sv % 2 == 1};
      M_D5P2:  return {sv % 5 == 3, (sv >= 3) && (((sv - 3) % 5) < 3)};
      M_D1:    return 2'b11;
      default: begin
        c = (sv - 1) % 255;
        return {sv % 255 == 0, (c == 254) || (c <= 126)};
      end
    endcase
  endfunction

  task automatic step(input logic rst, input logic we, input int ch, input int dv,
                      input int ph, input logic [NCH-1:0] en, input int new_mode,
                      input logic exp_err, input string tag);
    exp_t       e;
    logic       acc;
    logic [1:0] v;
    @(negedge CLKIN_IN);
    RST_IN        = rst;
    bus.CFG_WE    = we;
    bus.CFG_CH    = ch[CW-1:0];
    bus.CFG_DIV   = dv[DW-1:0];
    bus.CFG_PHASE = ph[DW-1:0];
    bus.CH_EN     = en;
    e.tag = tag;
    e.ce  = '0;
    e.clk = '0;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        s[i]    = 0;
        mode[i] = M_D2;
      end
      lk_n  = 0;
      e.lk  = 1'b0;
      e.err = 1'b0;
    end else begin
      acc = we && !exp_err;
      if (acc) lk_n = 0;
      else if (lk_n < LC) lk_n++;
      for (int i = 0; i < NCH; i++) begin
        if (acc && i == ch) begin
          mode[i] = new_mode;
          s[i]    = 0;
        end else if (!en[i]) begin
          s[i] = 0;
        end else begin
          s[i]++;
          v        = ch_exp(mode[i], s[i]);
          e.ce[i]  = v[1];
          e.clk[i] = v[0];
        end
      end
      e.lk  = (lk_n >= LC);
      e.err = exp_err;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [NCH-1:0] en, input string tag);
    repeat (n) step(1'b0, 1'b0, 0, 2, 0, en, M_D2, 1'b0, tag);
  endtask

  // Monitor: outputs are valid every edge; compare #1 after each edge.
  initial begin
    exp_t m;
    forever begin
      @(posedge CLKIN_IN);
      #1;
      if (q.size() > 0) begin
        m = q.pop_front();
        checks++;
        if (bus.CE_OUT !== m.ce) begin
          errors++;
          $display("FAIL %s ce_out got %h want %h", m.tag, bus.CE_OUT, m.ce);
        end
        checks++;
        if (bus.CLKOUT !== m.clk) begin
          errors++;
          $display("FAIL %s clkout got %h want %h", m.tag, bus.CLKOUT, m.clk);
        end
        checks++;
        if (bus.LOCKED_OUT !== m.lk) begin
          errors++;
          $display("FAIL %s locked got %b want %b", m.tag, bus.LOCKED_OUT, m.lk);
        end
        checks++;
        if (bus.CFG_ERR !== m.err) begin
          errors++;
          $display("FAIL %s cfg_err got %b want %b", m.tag, bus.CFG_ERR, m.err);
        end
      end
    end
  end

  initial begin
    RST_IN        = 1'b1;
    bus.CFG_WE    = 1'b0;
    bus.CFG_CH    = '0;
    bus.CFG_DIV   = '0;
    bus.CFG_PHASE = '0;
    bus.CH_EN     = 6'h3F;
    lk_n          = 0;
    for (int i = 0; i < NCH; i++) begin
      s[i]    = 0;
      mode[i] = M_D2;
    end

    // Reset, then free-running div=2 channels and first lock
    repeat (3) step(1'b1, 1'b0, 0, 2, 0, 6'h3F, M_D2, 1'b0, "reset");
    idle(20, 6'h3F, "t1_run");

    // ch2 reprogrammed to div=5 phase=2
    step(1'b0, 1'b1, 2, 5, 2, 6'h3F, M_D5P2, 1'b0, "t2_wr");
    idle(25, 6'h3F, "t2_run");

    // Rejected writes
    step(1'b0, 1'b1, 2, 0, 0, 6'h3F, M_D2, 1'b1, "t3_div0");
    idle(1, 6'h3F, "t3_gap");
    step(1'b0, 1'b1, 2, 4, 4, 6'h3F, M_D2, 1'b1, "t3_ph_ge_div");
    idle(1, 6'h3F, "t3_gap");
    step(1'b0, 1'b1, 6, 3, 0, 6'h3F, M_D2, 1'b1, "t3_ch6");
    idle(3, 6'h3F, "t3_after");

    // ch0 div=1, disabled for 4 cycles, re-enabled
    step(1'b0, 1'b1, 0, 1, 0, 6'h3F, M_D1, 1'b0, "t4_wr");
    idle(3, 6'h3F, "t4_on");
    idle(4, 6'h3E, "t4_off");
    idle(20, 6'h3F, "t4_reon");

    // ch5 div=255 phase=254, two full periods
    step(1'b0, 1'b1, 5, 255, 254, 6'h3F, M_D255, 1'b0, "t5_wr");
    idle(515, 6'h3F, "t5_run");

    // Reset mid-stream with a concurrent (ignored) write
    step(1'b1, 1'b1, 1, 7, 0, 6'h3F, M_D2, 1'b0, "t6_rst");
    idle(20, 6'h3F, "t6_run");

    for (int w = 0; w < 8; w++) begin
      if (q.size() == 0) break;
      @(posedge CLKIN_IN);
      #2;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_en_gen.md
Name: clk_en_gen

Overview:
- Parametrised multi-channel clock-enable generator.
- Successor to the fixed six-output DCM_100 wrapper. Derives NUM_CH independent divided enables and square waves from CLKIN_IN, with a run-time programmable divide ratio and phase per channel.
- Provides a LOCKED_OUT indication that downstream logic gates on.
- Purely synchronous fabric logic. No clock primitives; all outputs are registered in the CLKIN_IN domain.

Parameters:
- NUM_CH, 6, number of output channels (1..16).
- DIV_W, 8, width of the divide-ratio and phase fields.
- CH_W, 3, width of the channel-select field. Must satisfy 2^CH_W >= NUM_CH.
- LOCK_CYCLES, 16, quiet cycles after reset or after an accepted config write before LOCKED_OUT asserts (>=1).

Ports:
- CLKIN_IN  in  1  sole clock; all logic on the rising edge.
- RST_IN  in  1  reset, synchronous, active-high.
- CFG_WE  in  1  config write strobe, single cycle.
- CFG_CH  in  CH_W  channel index for the write.
- CFG_DIV  in  DIV_W  divide ratio for the write.
- CFG_PHASE  in  DIV_W  phase offset for the write.
- CH_EN  in  NUM_CH  per-channel run enable.
- CE_OUT  out  NUM_CH  one-cycle enable pulse per divided period.
- CLKOUT  out  NUM_CH  registered divided square wave.
- LOCKED_OUT  out  1  all channels stable.
- CFG_ERR  out  1  one-cycle pulse on a rejected write.

Behaviour:
- Interface: one clock, CLKIN_IN. Reset RST_IN is synchronous and active-high.
- Per-channel state: div[i], phase[i], cnt[i], all DIV_W bits.
- Reset values:
  - div = 2, phase = 0, cnt = 0.
  - CE_OUT = 0, CLKOUT = 0, LOCKED_OUT = 0, CFG_ERR = 0.
  - Lock counter = 0.
- Reset mid-operation: restores all of the above on the next edge and discards any write in that cycle.
- Counter, per edge:
  - If CH_EN[i]=0: cnt[i] <= 0, CE_OUT[i] <= 0, CLKOUT[i] <= 0.
  - Otherwise: CE_OUT[i] <= (cnt[i]==phase[i]), and cnt[i] <= (cnt[i]==div[i]-1) ? 0 : cnt[i]+1 (wrap at div-1).
- Square wave: p = (cnt[i] - phase[i]) mod div[i]; CLKOUT[i] <= (p < (div[i]+1)/2).
  - Even div gives 50% duty.
  - Odd div is high for one extra cycle.
  - div=1 gives CE_OUT and CLKOUT constantly 1 while enabled.
- Latency: CE_OUT and CLKOUT reflect the counter value present before the edge, i.e. one register stage.
- Config write (CFG_WE=1, not in reset):
  - Rejected if any of: CFG_CH >= NUM_CH, CFG_DIV==0, CFG_PHASE >= CFG_DIV.
    - Rejection: CFG_ERR <= 1 for one cycle; no state changes; lock unaffected.
  - Accepted: div/phase of CFG_CH updated and cnt[CFG_CH] <= 0.
    - CE_OUT and CLKOUT of that channel are forced 0 on that edge.
    - Counting resumes from 0 using the new values on the following edge.
    - Other channels are undisturbed.
  - Writes on consecutive cycles are each evaluated independently.
- Lock:
  - The lock counter clears on reset and on any accepted write, and increments (saturating) on every other edge.
  - LOCKED_OUT <= (counter reached LOCK_CYCLES). It is 0 on the clearing edge and rises exactly LOCK_CYCLES edges after the last reset or accepted write.
  - CH_EN changes do not affect lock.
- Simultaneous events:
  - Write to a channel whose CH_EN=0: config is stored and cnt stays 0.
  - CH_EN rising: counting starts from cnt=0. The first CE_OUT appears on the first edge with CH_EN=1 if phase=0.

Test Plan:
1. Reset 3 cycles, CH_EN=6'h3F, no writes.
   - Required: all CE_OUT toggle 1,0,1,0 starting at the first edge after reset release.
   - Required: CLKOUT follows 1,0,... on the same edges.
   - Required: LOCKED_OUT rises on edge 16.
2. Write ch2 with DIV=5, PHASE=2 after lock.
   - Required: LOCKED_OUT drops the same edge; CE_OUT[2] forced 0 on that edge.
   - Required: after the write, CE_OUT[2] pulses on edges 3, 8, 13.
   - Required: CLKOUT[2] is high 3 of every 5 cycles, starting on edge 3.
   - Required: LOCKED_OUT back to 1 sixteen edges later.
   - Required: ch0/1/3-5 unaffected.
3. Invalid writes: DIV=0; PHASE=4 with DIV=4; CFG_CH=6.
   - Required: each gives a 1-cycle CFG_ERR pulse.
   - Required: no config change; LOCKED_OUT stays 1.
4. Write ch0 with DIV=1, then CH_EN[0]=0 for 4 cycles, then 1.
   - Required: CE_OUT[0] and CLKOUT[0] constant 1 while enabled, 0 while disabled.
   - Required: both resume at 1 on the first re-enabled edge.
5. Write ch5 with DIV=255, PHASE=254.
   - Required: CE_OUT[5] pulses on edge 255 after the write, then every 255 edges; counter wraps 254->0 cleanly.
6. Assert RST_IN for 1 cycle mid-stream with CFG_WE=1.
   - Required: the write is ignored and all div values return to 2.
   - Required: outputs are 0 on the reset edge; LOCKED_OUT relocks after 16 edges.
